// File: rtl/serving_uart_loader.sv
// UART 8N1 boot loader: receives a length-prefixed image and writes it into RAM over Wishbone.
// Optional trailing checksum byte enabled by defining SERVING_LOADER_CHECKSUM_EN.
module serving_uart_loader #(
    parameter int aw      = 8,
    parameter int clk_div = 434
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_rx,
    output logic [aw-3:0] o_wb_adr,
    output logic [31:0]   o_wb_dat,
    output logic [3:0]    o_wb_sel,
    output logic          o_wb_we,
    output logic          o_wb_stb,
    input  logic          i_wb_ack,
    output logic          o_cpu_rst,
    output logic          o_done,
    output logic          o_err
);
    localparam logic [15:0] BIT_TICKS  = 16'(clk_div - 1);
    localparam logic [15:0] HALF_TICKS = 16'(clk_div / 2 - 1);
    localparam logic [31:0] MAX_LEN    = 32'(1) << aw;

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [2:0] {
        ST_LEN0, ST_LEN1, ST_DATA, ST_WRITE,
`ifdef SERVING_LOADER_CHECKSUM_EN
        ST_CSUM,
`endif
        ST_DONE, ST_ERR
    } state_t;

`ifdef SERVING_LOADER_CHECKSUM_EN
    localparam state_t ST_TAIL = ST_CSUM;
`else
    localparam state_t ST_TAIL = ST_DONE;
`endif

    function automatic logic [31:0] put_lane(input logic [31:0] word, input logic [1:0] lane,
                                             input logic [7:0] b);
        logic [31:0] r;
        r = word;
        r[{lane, 3'b000} +: 8] = b;
        return r;
    endfunction

    logic      rx_meta_r, rx_sync_r, rx_prev_r;
    rx_state_t rx_st_r;
    logic [15:0] rx_cnt_r;
    logic [2:0]  rx_bit_r;
    logic [7:0]  rx_shift_r;
    logic        rx_valid_r, rx_ferr_r;

    state_t      st_r;
    logic [7:0]  buf_r;
    logic        buf_full_r;
    logic [7:0]  len_lo_r;
    logic [15:0] rem_r;
    logic [1:0]  lane_r;
`ifdef SERVING_LOADER_CHECKSUM_EN
    logic [7:0]  sum_r;
`endif
    logic        take_s;
    logic [15:0] len_s;
    logic        fault_s;

    // Two-flop synchroniser plus one delay stage for start-edge detection
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            rx_meta_r <= 1'b1;
            rx_sync_r <= 1'b1;
            rx_prev_r <= 1'b1;
        end else begin
            rx_meta_r <= i_rx;
            rx_sync_r <= rx_meta_r;
            rx_prev_r <= rx_sync_r;
        end
    end

    // UART receiver: start-edge, mid-bit sampling, one-cycle byte/framing-error pulses
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            rx_st_r    <= RX_IDLE;
            rx_cnt_r   <= 16'd0;
            rx_bit_r   <= 3'd0;
            rx_shift_r <= 8'd0;
            rx_valid_r <= 1'b0;
            rx_ferr_r  <= 1'b0;
        end else begin
            rx_valid_r <= 1'b0;
            rx_ferr_r  <= 1'b0;
            case (rx_st_r)
                RX_IDLE: begin
                    if (rx_prev_r && !rx_sync_r) begin
                        rx_st_r  <= RX_START;
                        rx_cnt_r <= HALF_TICKS;
                    end
                end
                RX_START: begin
                    if (rx_cnt_r == 16'd0) begin
                        if (rx_sync_r) begin
                            rx_st_r <= RX_IDLE;
                        end else begin
                            rx_st_r  <= RX_DATA;
                            rx_cnt_r <= BIT_TICKS;
                            rx_bit_r <= 3'd0;
                        end
                    end else begin
                        rx_cnt_r <= rx_cnt_r - 16'd1;
                    end
                end
                RX_DATA: begin
                    if (rx_cnt_r == 16'd0) begin
                        rx_shift_r <= {rx_sync_r, rx_shift_r[7:1]};
                        rx_cnt_r   <= BIT_TICKS;
                        if (rx_bit_r == 3'd7) begin
                            rx_st_r <= RX_STOP;
                        end else begin
                            rx_bit_r <= rx_bit_r + 3'd1;
                        end
                    end else begin
                        rx_cnt_r <= rx_cnt_r - 16'd1;
                    end
                end
                RX_STOP: begin
                    if (rx_cnt_r == 16'd0) begin
                        rx_valid_r <= rx_sync_r;
                        rx_ferr_r  <= !rx_sync_r;
                        rx_st_r    <= RX_IDLE;
                    end else begin
                        rx_cnt_r <= rx_cnt_r - 16'd1;
                    end
                end
                default: rx_st_r <= RX_IDLE;
            endcase
        end
    end

    // Holding buffer is drained only in states that consume bytes
    always_comb begin
        take_s = 1'b0;
        case (st_r)
            ST_LEN0, ST_LEN1, ST_DATA: take_s = buf_full_r;
`ifdef SERVING_LOADER_CHECKSUM_EN
            ST_CSUM: take_s = buf_full_r;
`endif
            default: take_s = 1'b0;
        endcase
        len_s   = {buf_r, len_lo_r};
        fault_s = (st_r != ST_DONE) && (st_r != ST_ERR) &&
                  (rx_ferr_r || (rx_valid_r && buf_full_r && !take_s));
    end

    // Main loader FSM with registered Wishbone and status outputs
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            st_r       <= ST_LEN0;
            buf_r      <= 8'd0;
            buf_full_r <= 1'b0;
            len_lo_r   <= 8'd0;
            rem_r      <= 16'd0;
            lane_r     <= 2'd0;
`ifdef SERVING_LOADER_CHECKSUM_EN
            sum_r      <= 8'd0;
`endif
            o_wb_adr   <= '0;
            o_wb_dat   <= 32'd0;
            o_wb_sel   <= 4'd0;
            o_wb_we    <= 1'b0;
            o_wb_stb   <= 1'b0;
            o_cpu_rst  <= 1'b1;
            o_done     <= 1'b0;
            o_err      <= 1'b0;
        end else begin
            o_done    <= (st_r == ST_DONE);
            o_err     <= (st_r == ST_ERR);
            o_cpu_rst <= (st_r != ST_DONE);

            if (rx_valid_r) begin
                buf_r      <= rx_shift_r;
                buf_full_r <= 1'b1;
            end else if (take_s) begin
                buf_full_r <= 1'b0;
            end
`ifdef SERVING_LOADER_CHECKSUM_EN
            if (take_s) begin
                sum_r <= sum_r + buf_r;
            end
`endif

            if (fault_s) begin
                st_r     <= ST_ERR;
                o_wb_stb <= 1'b0;
                o_wb_we  <= 1'b0;
            end else begin
                case (st_r)
                    ST_LEN0: begin
                        if (take_s) begin
                            len_lo_r <= buf_r;
                            st_r     <= ST_LEN1;
                        end
                    end
                    ST_LEN1: begin
                        if (take_s) begin
                            rem_r <= len_s;
                            if ({16'd0, len_s} > MAX_LEN) begin
                                st_r <= ST_ERR;
                            end else if (len_s == 16'd0) begin
                                st_r <= ST_TAIL;
                            end else begin
                                st_r <= ST_DATA;
                            end
                        end
                    end
                    ST_DATA: begin
                        if (take_s) begin
                            o_wb_dat         <= put_lane(o_wb_dat, lane_r, buf_r);
                            o_wb_sel[lane_r] <= 1'b1;
                            lane_r           <= lane_r + 2'd1;
                            rem_r            <= rem_r - 16'd1;
                            if (lane_r == 2'd3 || rem_r == 16'd1) begin
                                st_r     <= ST_WRITE;
                                o_wb_stb <= 1'b1;
                                o_wb_we  <= 1'b1;
                            end
                        end
                    end
                    ST_WRITE: begin
                        if (i_wb_ack) begin
                            o_wb_stb <= 1'b0;
                            o_wb_we  <= 1'b0;
                            o_wb_sel <= 4'd0;
                            o_wb_dat <= 32'd0;
                            o_wb_adr <= o_wb_adr + (aw-2)'(1);
                            st_r     <= (rem_r != 16'd0) ? ST_DATA : ST_TAIL;
                        end
                    end
`ifdef SERVING_LOADER_CHECKSUM_EN
                    ST_CSUM: begin
                        if (take_s) begin
                            st_r <= (buf_r == sum_r) ? ST_DONE : ST_ERR;
                        end
                    end
`endif
                    ST_DONE, ST_ERR: begin
                        o_wb_stb <= 1'b0;
                        o_wb_we  <= 1'b0;
                    end
                    default: begin
                        st_r     <= ST_ERR;
                        o_wb_stb <= 1'b0;
                        o_wb_we  <= 1'b0;
                    end
                endcase
            end
        end
    end
endmodule
